// File: rtl/mc_ctrl_if.sv
// Unified memory port between the multi-cycle controller and instruction/data memory.
interface mc_ctrl_if;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ready;
    logic       iord;
    logic [2:0] dm_type;

    modport master (output mem_req, output mem_we, output iord, output dm_type, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, input dm_type, output mem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared memory port.
// Optional performance counters (cycle_cnt, instret_cnt) are enabled with `define MC_CTRL_PERF_EN.
module mc_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    mc_ctrl_if.master  mem,
    output logic       ir_write,
    output logic       pc_write,
    output logic [2:0] npc_op,
    output logic       reg_write,
    output logic [1:0] wd_sel,
    output logic       alu_src_b,
    output logic [4:0] alu_op,
    output logic [5:0] ext_op,
    output logic       trap,
    output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr;
    logic             legal;
    logic             timeout_hit;
    logic             req_state;
    logic             br_taken;

    assign is_r    = (op == OP_R);
    assign is_i    = (op == OP_I);
    assign is_ld   = (op == OP_LD);
    assign is_st   = (op == OP_ST);
    assign is_br   = (op == OP_BR);
    assign is_jal  = (op == OP_JAL);
    assign is_jalr = (op == OP_JALR);

    assign req_state   = (cur == FETCH) || (cur == MEM);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TIMEOUT_C);
    assign br_taken    = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

    always_comb begin
        legal = 1'b0;
        if (is_r)
            legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        else if (is_i || is_jal)
            legal = 1'b1;
        else if (is_ld)
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        else if (is_st)
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else if (is_br)
            legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        else if (is_jalr)
            legal = (funct3 == 3'b000);
    end

    // A completion in the same cycle the counter hits TIMEOUT takes priority over the trap.
    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:  if (mem.mem_ready) nxt = DECODE;
                    else if (timeout_hit) nxt = TRAP;
            DECODE: nxt = legal ? EXEC : TRAP;
            EXEC:   if (is_ld || is_st) nxt = MEM;
                    else if (is_br) nxt = FETCH;
                    else nxt = WB;
            MEM:    if (mem.mem_ready) nxt = is_st ? FETCH : WB;
                    else if (timeout_hit) nxt = TRAP;
            WB:     nxt = FETCH;
            TRAP:   nxt = TRAP;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur      <= FETCH;
            wait_cnt <= '0;
`ifdef MC_CTRL_PERF_EN
            cycle_cnt   <= '0;
            instret_cnt <= '0;
`endif
        end else begin
            cur <= nxt;
            if (req_state && !mem.mem_ready && (nxt == cur))
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
`ifdef MC_CTRL_PERF_EN
            if (cur != TRAP)
                cycle_cnt <= cycle_cnt + 32'd1;
            if ((nxt == FETCH) && ((cur == EXEC) || (cur == MEM) || (cur == WB)))
                instret_cnt <= instret_cnt + 32'd1;
`endif
        end
    end

    // FETCH outputs are gated by rstn so the request drops the moment reset is asserted.
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.iord    = 1'b0;
        mem.dm_type = 3'b000;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        npc_op      = 3'b000;
        reg_write   = 1'b0;
        wd_sel      = 2'b00;
        alu_src_b   = 1'b0;
        alu_op      = 5'b00000;
        ext_op      = 6'b000000;
        trap        = 1'b0;
        case (cur)
            FETCH: begin
                if (rstn) begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (is_r) begin
                    alu_op = {1'b0, funct7[5], funct3};
                end else if (is_i) begin
                    alu_src_b = 1'b1;
                    alu_op    = {1'b0, funct7[5] & (funct3 == 3'b101), funct3};
                    ext_op    = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? 6'b100000 : 6'b010000;
                end else if (is_ld || is_st) begin
                    alu_src_b = 1'b1;
                    ext_op    = is_ld ? 6'b010000 : 6'b001000;
                end else if (is_br) begin
                    alu_op = 5'b01000;
                    ext_op = 6'b000100;
                    if (br_taken) begin
                        pc_write = 1'b1;
                        npc_op   = 3'b001;
                    end
                end else if (is_jal) begin
                    ext_op   = 6'b000001;
                    pc_write = 1'b1;
                    npc_op   = 3'b010;
                end else if (is_jalr) begin
                    ext_op    = 6'b010000;
                    alu_src_b = 1'b1;
                    pc_write  = 1'b1;
                    npc_op    = 3'b100;
                end
            end
            MEM: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                mem.dm_type = funct3;
                mem.mem_we  = is_st;
            end
            WB: begin
                reg_write = 1'b1;
                if (is_ld)
                    wd_sel = 2'b01;
                else if (is_jal || is_jalr)
                    wd_sel = 2'b10;
            end
            TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed per-cycle vectors push expected outputs, a negedge monitor compares.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [2:0] npc_op;
        logic       reg_write;
        logic [1:0] wd_sel;
        logic       alu_src_b;
        logic [4:0] alu_op;
        logic [5:0] ext_op;
        logic [2:0] dm_type;
        logic       trap;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } entry_t;

    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] SUB   = 32'h40208133;
    localparam logic [31:0] SRAI  = 32'h4030D093;
    localparam logic [31:0] LW    = 32'h0080A283;
    localparam logic [31:0] SW    = 32'h0020A223;
    localparam logic [31:0] BEQ   = 32'h00000063;
    localparam logic [31:0] BNE   = 32'h00001063;
    localparam logic [31:0] JALR  = 32'h000100E7;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] ILLR  = 32'h40209133;

    logic       clk;
    logic       rstn;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       ir_write, pc_write, reg_write, alu_src_b, trap;
    logic [2:0] npc_op, state;
    logic [1:0] wd_sel;
    logic [4:0] alu_op;
    logic [5:0] ext_op;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
    logic [31:0] perf_q[$];
`endif

    entry_t sb_q[$];
    int     n_vec  = 0;
    int     n_fail = 0;

    mc_ctrl_if mem_if ();

    mc_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .zero      (zero),
        .mem       (mem_if),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .npc_op    (npc_op),
        .reg_write (reg_write),
        .wd_sel    (wd_sel),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .ext_op    (ext_op),
        .trap      (trap),
        .state     (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] st, input logic rq, input logic we, input logic io,
                                input logic irw, input logic pcw, input logic [2:0] npc,
                                input logic rw, input logic [1:0] wd, input logic sb,
                                input logic [4:0] ao, input logic [5:0] eo, input logic [2:0] dm,
                                input logic tr);
        exp_t e;
        e = '{st, rq, we, io, irw, pcw, npc, rw, wd, sb, ao, eo, dm, tr};
        return e;
    endfunction

    // One vector = one clock cycle: drive inputs just after the rising edge and queue what must be seen.
    task automatic apply_stimulus(input string tag, input logic r_n, input logic [31:0] instr,
                                  input logic rdy, input logic z, input exp_t e);
        entry_t ent;
        @(posedge clk);
        #1;
        rstn             = r_n;
        op               = instr[6:0];
        funct3           = instr[14:12];
        funct7           = instr[31:25];
        zero             = z;
        mem_if.mem_ready = rdy;
        ent.e   = e;
        ent.tag = tag;
        sb_q.push_back(ent);
    endtask

    task automatic fetch_ok(input string tag, input logic [31:0] instr);
        apply_stimulus(tag, 1'b1, instr, 1'b1, 1'b0, mk(3'd0,1,0,0,1,1,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b000,0));
    endtask

    task automatic fetch_wait(input string tag, input logic [31:0] instr);
        apply_stimulus(tag, 1'b1, instr, 1'b0, 1'b0, mk(3'd0,1,0,0,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b000,0));
    endtask

    task automatic decode(input string tag, input logic [31:0] instr);
        apply_stimulus(tag, 1'b1, instr, 1'b0, 1'b0, mk(3'd1,0,0,0,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b000,0));
    endtask

    task automatic reset_vec(input string tag);
        apply_stimulus(tag, 1'b0, 32'h0, 1'b1, 1'b0, mk(3'd0,0,0,0,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b000,0));
    endtask

    task automatic trap_vec(input string tag);
        apply_stimulus(tag, 1'b1, ILL, 1'b1, 1'b0, mk(3'd5,0,0,0,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b000,1));
    endtask

    task automatic run_add(input string tag);
        fetch_ok({tag, "_f"}, ADD);
        decode({tag, "_d"}, ADD);
        apply_stimulus({tag, "_ex"}, 1'b1, ADD, 1'b1, 1'b0, mk(3'd2,0,0,0,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b000,0));
        apply_stimulus({tag, "_wb"}, 1'b1, ADD, 1'b1, 1'b0, mk(3'd4,0,0,0,0,0,3'b000,1,2'b00,0,5'b00000,6'b000000,3'b000,0));
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest pending expectation.
    task automatic check_output();
        entry_t ent;
        exp_t   act;
        act = '{state, mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_write, pc_write, npc_op,
                reg_write, wd_sel, alu_src_b, alu_op, ext_op, mem_if.dm_type, trap};
        ent = sb_q.pop_front();
        n_vec++;
        if (act !== ent.e) begin
            n_fail++;
            $display("[TB] FAIL %s: got state=%0d bits=%h, want state=%0d bits=%h",
                     ent.tag, act.state, act, ent.e.state, ent.e);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0)
            check_output();
`ifdef MC_CTRL_PERF_EN
        if (perf_q.size() > 0) begin
            logic [31:0] want;
            want = perf_q.pop_front();
            n_vec++;
            if (instret_cnt !== want) begin
                n_fail++;
                $display("[TB] FAIL instret_cnt: got %0d want %0d", instret_cnt, want);
            end
        end
`endif
    end

    initial begin
        rstn             = 1'b0;
        op               = 7'd0;
        funct3           = 3'd0;
        funct7           = 7'd0;
        zero             = 1'b0;
        mem_if.mem_ready = 1'b0;

        reset_vec("reset");

        run_add("add");

        fetch_ok("lw_f", LW);
        decode("lw_d", LW);
        apply_stimulus("lw_ex", 1'b1, LW, 1'b0, 1'b0, mk(3'd2,0,0,0,0,0,3'b000,0,2'b00,1,5'b00000,6'b010000,3'b000,0));
        for (int i = 0; i < 3; i++)
            apply_stimulus("lw_mem_wait", 1'b1, LW, 1'b0, 1'b0, mk(3'd3,1,0,1,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b010,0));
        apply_stimulus("lw_mem_done", 1'b1, LW, 1'b1, 1'b0, mk(3'd3,1,0,1,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b010,0));
        apply_stimulus("lw_wb", 1'b1, LW, 1'b1, 1'b0, mk(3'd4,0,0,0,0,0,3'b000,1,2'b01,0,5'b00000,6'b000000,3'b000,0));

        fetch_ok("sw_f", SW);
        decode("sw_d", SW);
        apply_stimulus("sw_ex", 1'b1, SW, 1'b1, 1'b0, mk(3'd2,0,0,0,0,0,3'b000,0,2'b00,1,5'b00000,6'b001000,3'b000,0));
        apply_stimulus("sw_mem", 1'b1, SW, 1'b1, 1'b0, mk(3'd3,1,1,1,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b010,0));

        fetch_ok("beq_t_f", BEQ);
        decode("beq_t_d", BEQ);
        apply_stimulus("beq_taken", 1'b1, BEQ, 1'b1, 1'b1, mk(3'd2,0,0,0,0,1,3'b001,0,2'b00,0,5'b01000,6'b000100,3'b000,0));
        fetch_ok("beq_n_f", BEQ);
        decode("beq_n_d", BEQ);
        apply_stimulus("beq_not_taken", 1'b1, BEQ, 1'b1, 1'b0, mk(3'd2,0,0,0,0,0,3'b000,0,2'b00,0,5'b01000,6'b000100,3'b000,0));
        fetch_ok("bne_f", BNE);
        decode("bne_d", BNE);
        apply_stimulus("bne_taken", 1'b1, BNE, 1'b1, 1'b0, mk(3'd2,0,0,0,0,1,3'b001,0,2'b00,0,5'b01000,6'b000100,3'b000,0));

        fetch_ok("jalr_f", JALR);
        decode("jalr_d", JALR);
        apply_stimulus("jalr_ex", 1'b1, JALR, 1'b1, 1'b0, mk(3'd2,0,0,0,0,1,3'b100,0,2'b00,1,5'b00000,6'b010000,3'b000,0));
        apply_stimulus("jalr_wb", 1'b1, JALR, 1'b1, 1'b0, mk(3'd4,0,0,0,0,0,3'b000,1,2'b10,0,5'b00000,6'b000000,3'b000,0));

        fetch_ok("srai_f", SRAI);
        decode("srai_d", SRAI);
        apply_stimulus("srai_ex", 1'b1, SRAI, 1'b1, 1'b0, mk(3'd2,0,0,0,0,0,3'b000,0,2'b00,1,5'b01101,6'b100000,3'b000,0));
        apply_stimulus("srai_wb", 1'b1, SRAI, 1'b1, 1'b0, mk(3'd4,0,0,0,0,0,3'b000,1,2'b00,0,5'b00000,6'b000000,3'b000,0));

        fetch_ok("sub_f", SUB);
        decode("sub_d", SUB);
        apply_stimulus("sub_ex", 1'b1, SUB, 1'b1, 1'b0, mk(3'd2,0,0,0,0,0,3'b000,0,2'b00,0,5'b01000,6'b000000,3'b000,0));
        apply_stimulus("sub_wb", 1'b1, SUB, 1'b1, 1'b0, mk(3'd4,0,0,0,0,0,3'b000,1,2'b00,0,5'b00000,6'b000000,3'b000,0));

        // Ready arriving on the very cycle the wait counter reaches TIMEOUT must complete the fetch.
        for (int i = 0; i < 4; i++)
            fetch_wait("edge_wait", ADD);
        run_add("edge_add");

        // Asynchronous reset in the middle of a data request.
        fetch_ok("rst_f", LW);
        decode("rst_d", LW);
        apply_stimulus("rst_ex", 1'b1, LW, 1'b0, 1'b0, mk(3'd2,0,0,0,0,0,3'b000,0,2'b00,1,5'b00000,6'b010000,3'b000,0));
        apply_stimulus("rst_mem", 1'b1, LW, 1'b0, 1'b0, mk(3'd3,1,0,1,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b010,0));
        apply_stimulus("rst_mid_req", 1'b0, LW, 1'b0, 1'b0, mk(3'd0,0,0,0,0,0,3'b000,0,2'b00,0,5'b00000,6'b000000,3'b000,0));
        run_add("post_rst");

        fetch_ok("ill_f", ILL);
        decode("ill_d", ILL);
        trap_vec("ill_trap");
        trap_vec("ill_sticky");
        reset_vec("ill_reset");

        fetch_ok("illr_f", ILLR);
        decode("illr_d", ILLR);
        trap_vec("illr_trap");
        reset_vec("illr_reset");

        for (int i = 0; i < 5; i++)
            fetch_wait("to_wait", ADD);
        trap_vec("to_trap");
        trap_vec("to_sticky");
        reset_vec("to_reset");

`ifdef MC_CTRL_PERF_EN
        for (int i = 0; i < 10; i++)
            run_add("perf_add");
        fetch_wait("perf_f", ADD);
        perf_q.push_back(32'd10);
`endif

        for (int i = 0; i < 5 && sb_q.size() > 0; i++)
            @(negedge clk);
        @(posedge clk);
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
